// File: rtl/rc4_ks_pkg.sv
// Shared types and helpers for the RC4 keystream scheduler.
// Holds the FSM state encoding, default blanking length and one-hot decode.
package rc4_ks_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ADV  = 2'd2
    } state_t;

    localparam int SETTLE_CYC_DEFAULT = 2;
    localparam int MAX_REQ            = 8;
    localparam int MAX_IDX_W          = 3;

    // Index of the set bit in a one-hot vector; zero vector decodes to 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rc4_ks_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester strictly above the
// pointer, wrapping to the lowest eligible one when none is above it.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick_src;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign upper_mask[gi] = (gi > int'(ptr));
    end

    assign upper    = eligible & upper_mask;
    assign pick_src = (|upper) ? upper : eligible;

    // Isolate the lowest set bit of the candidate set.
    assign pick  = pick_src & (~pick_src + NUM_REQ'(1));
    assign valid = |eligible;

endmodule

// File: rtl/rc4_ks_scheduler.sv
// Shares one RC4 keystream core among NUM_REQ requesters: round-robin burst
// grants, core valid/advance handshake with stale-valid blanking.
module rc4_ks_scheduler
    import rc4_ks_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 8,
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ks_valid,
    output logic [7:0]               ks_data,
    output logic                     ks_last,
    output logic                     busy,
    input  logic                     core_key_valid,
    input  logic [7:0]               core_dout,
    output logic                     core_nxt_key
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]     count_reg, count_next;
    logic [SET_W-1:0]     settle_reg, settle_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [NUM_REQ-1:0]   ks_valid_reg, ks_valid_next;
    logic [7:0]           ks_data_reg, ks_data_next;
    logic                 ks_last_reg, ks_last_next;
    logic                 busy_reg, busy_next;
    logic                 nxt_key_reg, nxt_key_next;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [LEN_W-1:0]     len_masked [NUM_REQ];
    logic [LEN_W-1:0]     picked_len;
    logic [MAX_REQ-1:0]   grant_pad;
    logic                 core_ok;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign eligible[gi]   = req[gi] && (req_len[gi*LEN_W +: LEN_W] != '0);
        assign len_masked[gi] = pick[gi] ? req_len[gi*LEN_W +: LEN_W] : '0;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr_reg),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        picked_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            picked_len = picked_len | len_masked[i];
        end
    end

    always_comb begin
        grant_pad                = '0;
        grant_pad[NUM_REQ-1:0]   = grant_reg;
    end

    // A valid seen while blanking may still belong to the byte just consumed.
    assign core_ok = core_key_valid && (settle_reg == '0);

    always_comb begin
        if (nxt_key_reg) begin
            settle_next = SET_W'(SETTLE_CYC);
        end else if (settle_reg != '0) begin
            settle_next = settle_reg - SET_W'(1);
        end else begin
            settle_next = settle_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        count_next    = count_reg;
        grant_next    = grant_reg;
        ks_valid_next = '0;
        ks_data_next  = ks_data_reg;
        ks_last_next  = 1'b0;
        nxt_key_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick;
                    count_next = picked_len;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (core_ok) begin
                    nxt_key_next  = 1'b1;
                    ks_data_next  = core_dout;
                    ks_valid_next = grant_reg;
                    count_next    = count_reg - LEN_W'(1);
                    ks_last_next  = (count_reg == LEN_W'(1));
                    state_next    = ADV;
                end
            end
            ADV: begin
                if (count_reg == '0) begin
                    grant_next  = '0;
                    rr_ptr_next = IDX_W'(onehot_to_idx(grant_pad));
                    state_next  = IDLE;
                end else begin
                    state_next  = WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= IDX_W'(NUM_REQ - 1);
            count_reg    <= '0;
            settle_reg   <= SET_W'(SETTLE_CYC);
            grant_reg    <= '0;
            ks_valid_reg <= '0;
            ks_data_reg  <= '0;
            ks_last_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            nxt_key_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            count_reg    <= count_next;
            settle_reg   <= settle_next;
            grant_reg    <= grant_next;
            ks_valid_reg <= ks_valid_next;
            ks_data_reg  <= ks_data_next;
            ks_last_reg  <= ks_last_next;
            busy_reg     <= busy_next;
            nxt_key_reg  <= nxt_key_next;
        end
    end

    assign grant        = grant_reg;
    assign ks_valid     = ks_valid_reg;
    assign ks_data      = ks_data_reg;
    assign ks_last      = ks_last_reg;
    assign busy         = busy_reg;
    assign core_nxt_key = nxt_key_reg;

endmodule

// File: tb/tb_rc4_ks_scheduler.sv
// Randomized bench for rc4_ks_scheduler: behavioural RC4-core model with stale
// valid and variable turnaround, plus a transaction-level scoreboard.
module tb_rc4_ks_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int NBYTES  = 4096;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       ks_valid;
    logic [7:0]               ks_data;
    logic                     ks_last;
    logic                     busy;
    logic                     core_key_valid;
    logic [7:0]               core_dout;
    logic                     core_nxt_key;

    rc4_ks_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LEN_W      (LEN_W),
        .SETTLE_CYC (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_len        (req_len),
        .grant          (grant),
        .ks_valid       (ks_valid),
        .ks_data        (ks_data),
        .ks_last        (ks_last),
        .busy           (busy),
        .core_key_valid (core_key_valid),
        .core_dout      (core_dout),
        .core_nxt_key   (core_nxt_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- core model ----------------
    logic [7:0] core_bytes [NBYTES];
    int  core_idx;
    int  stale_left;
    int  gap_left;
    bit  pending;
    bit  stale_force;

    initial begin
        for (int i = 0; i < NBYTES; i++) core_bytes[i] = 8'($urandom);
        core_bytes[0] = 8'hA1;
        core_bytes[1] = 8'hB2;
        core_bytes[2] = 8'hC3;
        core_idx       = 0;
        pending        = 1'b0;
        stale_force    = 1'b0;
        core_key_valid = 1'b1;
        core_dout      = core_bytes[0];
        forever begin
            @(negedge clk);
            if (core_nxt_key && !pending) begin
                // Old byte keeps valid high for a while before the core recomputes.
                pending    = 1'b1;
                stale_left = stale_force ? 2 : int'($urandom_range(0, 2));
                gap_left   = int'($urandom_range(0, 3));
            end else if (pending) begin
                if (stale_left > 0) begin
                    stale_left--;
                end else if (gap_left > 0) begin
                    core_key_valid = 1'b0;
                    gap_left--;
                end else begin
                    core_idx++;
                    core_dout      = core_bytes[core_idx % NBYTES];
                    core_key_valid = 1'b1;
                    pending        = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [NUM_REQ-1:0]       req_q = '0;
    logic [NUM_REQ*LEN_W-1:0] len_q = '0;
    bit   in_burst   = 1'b0;
    bit   drop_due   = 1'b0;
    int   exp_req    = 0;
    int   remaining  = 0;
    int   last_served = NUM_REQ - 1;
    int   exp_ptr    = 0;
    int   burst_bytes = 0;
    int   vld_pulses = 0;
    int   nxt_pulses = 0;
    int   mon_pick;
    int   grant_log [$];
    logic [7:0] byte_log [$];

    function automatic int ref_pick(input logic [NUM_REQ-1:0] r,
                                    input logic [NUM_REQ*LEN_W-1:0] l,
                                    input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = (last + i) % NUM_REQ;
            if (r[k] && l[k*LEN_W +: LEN_W] != 0) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_burst    = 1'b0;
            drop_due    = 1'b0;
            remaining   = 0;
            last_served = NUM_REQ - 1;
        end else begin
            if (drop_due) begin
                check_value("grant_drop", 32'(grant), 32'd0);
                check_value("busy_drop", 32'(busy), 32'd0);
                drop_due    = 1'b0;
                in_burst    = 1'b0;
                last_served = exp_req;
            end else if (in_burst) begin
                check_value("grant_hold", 32'(grant), 32'(1 << exp_req));
            end else if (grant != '0) begin
                mon_pick = ref_pick(req_q, len_q, last_served);
                check_value("grant_pick", 32'(grant), (mon_pick < 0) ? 32'd0 : 32'(1 << mon_pick));
                check_value("busy_on", 32'(busy), 32'd1);
                if (mon_pick >= 0) begin
                    in_burst    = 1'b1;
                    exp_req     = mon_pick;
                    remaining   = int'(len_q[mon_pick*LEN_W +: LEN_W]);
                    burst_bytes = 0;
                    grant_log.push_back(mon_pick);
                end
            end
            if (ks_valid != '0) begin
                vld_pulses++;
                check_value("ks_valid", 32'(ks_valid), in_burst ? 32'(1 << exp_req) : 32'd0);
                check_value("ks_data", 32'(ks_data), 32'(core_bytes[exp_ptr % NBYTES]));
                check_value("ks_last", 32'(ks_last), (remaining == 1) ? 32'd1 : 32'd0);
                check_value("nxt_with_byte", 32'(core_nxt_key), 32'd1);
                byte_log.push_back(ks_data);
                exp_ptr++;
                remaining--;
                burst_bytes++;
                if (remaining <= 0) drop_due = 1'b1;
            end else if (ks_last || core_nxt_key) begin
                check_value("strobe_alone", 32'({ks_last, core_nxt_key}), 32'd0);
            end
            if (core_nxt_key) nxt_pulses++;
        end
        req_q = req;
        len_q = req_len;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int k, input int v);
        req_len[k*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic wait_grant(input string tag);
        int c;
        c = 0;
        while (!in_burst && c < 3000) begin step(); c++; end
        if (!in_burst) check_value(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        step(); step();
        while ((busy || in_burst || drop_due) && c < 3000) begin step(); c++; end
        if (busy || in_burst || drop_due) check_value(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_grant"},  32'(grant), 32'd0);
        check_value({tag, "_valid"},  32'(ks_valid), 32'd0);
        check_value({tag, "_data"},   32'(ks_data), 32'd0);
        check_value({tag, "_last"},   32'(ks_last), 32'd0);
        check_value({tag, "_busy"},   32'(busy), 32'd0);
        check_value({tag, "_nxt"},    32'(core_nxt_key), 32'd0);
    endtask

    initial begin
        logic [7:0] t1_exp [3];
        int base;
        int seen2;
        int c;
        t1_exp[0] = 8'hA1; t1_exp[1] = 8'hB2; t1_exp[2] = 8'hC3;

        rst = 1'b1; req = '0; req_len = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst_init");
        rst = 1'b0;

        // 1: single requester, three bytes
        set_len(0, 3); req = 4'b0001;
        wait_grant("t1_grant_timeout");
        req = '0;
        wait_idle("t1_idle_timeout");
        for (int i = 0; i < 3; i++) check_value("t1_byte", 32'(byte_log[i]), 32'(t1_exp[i]));
        check_value("t1_len", 32'(burst_bytes), 32'd3);

        // 2: all request len 1 after reset, pointer starts at NUM_REQ-1
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) set_len(k, 1);
        base = grant_log.size();
        req = 4'b1111;
        c = 0;
        while (grant_log.size() < base + 4 && c < 3000) begin step(); c++; end
        req = '0;
        wait_idle("t2_idle_timeout");
        for (int i = 0; i < 4; i++) check_value("t2_order", 32'(grant_log[base + i]), 32'(i));

        // 3: stale valid held through the blanking window
        stale_force = 1'b1;
        set_len(2, 6); req = 4'b0100;
        wait_grant("t3_grant_timeout");
        req = '0;
        wait_idle("t3_idle_timeout");
        stale_force = 1'b0;
        check_value("t3_pulses", 32'(nxt_pulses), 32'(vld_pulses));
        check_value("t3_len", 32'(burst_bytes), 32'd6);

        // 4: zero-length request never granted
        set_len(1, 2); set_len(2, 0);
        base = grant_log.size();
        req = 4'b0110;
        c = 0;
        while (grant_log.size() < base + 2 && c < 3000) begin step(); c++; end
        req = '0;
        wait_idle("t4_idle_timeout");
        seen2 = 0;
        for (int i = base; i < grant_log.size(); i++) if (grant_log[i] == 2) seen2++;
        check_value("t4_no_req2", 32'(seen2), 32'd0);

        // 5: req dropped after first byte, burst still completes
        set_len(0, 5); req = 4'b0001;
        wait_grant("t5_grant_timeout");
        c = 0;
        while (burst_bytes < 1 && c < 3000) begin step(); c++; end
        req = '0;
        wait_idle("t5_idle_timeout");
        check_value("t5_len", 32'(burst_bytes), 32'd5);

        // 6: reset in WAIT after two bytes of a four-byte burst
        set_len(3, 4); req = 4'b1000;
        wait_grant("t6_grant_timeout");
        c = 0;
        while (burst_bytes < 2 && c < 3000) begin step(); c++; end
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        base = byte_log.size();
        step();
        rst = 1'b0;
        wait_grant("t6_regrant_timeout");
        c = 0;
        while (byte_log.size() <= base && c < 3000) begin step(); c++; end
        req = '0;
        wait_idle("t6_idle_timeout");
        check_value("t6_fresh", 32'(byte_log[base]), 32'(core_bytes[base]));

        // maximum burst length
        set_len(1, 255); req = 4'b0010;
        wait_grant("max_grant_timeout");
        req = '0;
        wait_idle("max_idle_timeout");
        check_value("max_len", 32'(burst_bytes), 32'd255);

        // randomized requests and lengths
        for (int it = 0; it < 60; it++) begin
            req = NUM_REQ'($urandom);
            for (int k = 0; k < NUM_REQ; k++)
                set_len(k, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5)));
            repeat ($urandom_range(1, 15)) step();
        end
        req = '0;
        wait_idle("rand_idle_timeout");
        check_value("rand_pulses", 32'(nxt_pulses), 32'(vld_pulses));

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
